// File: rtl/warp_inst_issuer.sv
// -----------------------------------------------------------------------------
// warp_inst_issuer
//
// Accepts one warp at a time, then issues its instructions (pc 0 .. n_inst-1)
// to the SIMD stage, keeping at most MAX_OUT instructions in flight between
// issue and commit. When every instruction of the warp has been committed a
// single-cycle done pulse carries the warp id back to the scheduler.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   warp_rdy/warp_ack   warp request handshake (ack only while idle)
//   i_wid, i_bofs,      warp payload: id, block offsets, accumulation
//   i_aofs, i_n_inst    offsets, instruction count (clamped to N_INST)
//   inst_rdy/inst_ack   instruction issue handshake towards the SIMD stage
//   o_pc, o_wid,        issued instruction: pc, warp id and the offsets
//   o_bofs, o_aofs      latched with the warp
//   inst_commit_dval    one pulse per committed instruction
//   warp_done_dval      one-cycle pulse when the warp is fully committed
//   o_done_wid          warp id qualified by warp_done_dval
//   o_err               sticky: a commit arrived with nothing outstanding
//
// Offsets are carried as flat vectors of VDIM lanes of WBW bits each.
// -----------------------------------------------------------------------------
module warp_inst_issuer #(
  parameter int WBW      = 16,
  parameter int VDIM     = 6,
  parameter int N_INST   = 8,
  parameter int MAX_WARP = 4,
  parameter int MAX_OUT  = 4,
  localparam int INST_BW = $clog2(N_INST + 1),
  localparam int WID_BW  = (MAX_WARP > 1) ? $clog2(MAX_WARP) : 1,
  localparam int OUT_BW  = $clog2(MAX_OUT + 1),
  localparam int OFS_BW  = WBW * VDIM
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               warp_rdy,
  output logic               warp_ack,
  input  logic [WID_BW-1:0]  i_wid,
  input  logic [OFS_BW-1:0]  i_bofs,
  input  logic [OFS_BW-1:0]  i_aofs,
  input  logic [INST_BW-1:0] i_n_inst,
  output logic               inst_rdy,
  input  logic               inst_ack,
  output logic [INST_BW-1:0] o_pc,
  output logic [WID_BW-1:0]  o_wid,
  output logic [OFS_BW-1:0]  o_bofs,
  output logic [OFS_BW-1:0]  o_aofs,
  input  logic               inst_commit_dval,
  output logic               warp_done_dval,
  output logic [WID_BW-1:0]  o_done_wid,
  output logic               o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [INST_BW-1:0]   r_pc;
  logic [INST_BW-1:0]   r_hold_pc;
  logic [INST_BW-1:0]   r_n_inst;
  logic [WID_BW-1:0]    r_wid;
  logic [OFS_BW-1:0]    r_bofs;
  logic [OFS_BW-1:0]    r_aofs;
  logic [OUT_BW-1:0]    r_out;
  logic                 r_err;

  logic                 w_warp_take;
  logic                 w_inst_avail;
  logic                 w_done;
  logic                 w_inst_fire;
  logic [INST_BW-1:0]   w_pc_inc;
  logic [INST_BW-1:0]   w_n_clamped;
  logic [OUT_BW-1:0]    w_out_next;
  logic                 w_underflow;

  assign w_pc_inc = r_pc + {{(INST_BW-1){1'b0}}, 1'b1};

  // Clamp the requested instruction count to what a warp may hold.
  always_comb begin
    w_n_clamped = i_n_inst;
    if (i_n_inst > INST_BW'(N_INST)) begin
      w_n_clamped = INST_BW'(N_INST);
    end else begin
      w_n_clamped = i_n_inst;
    end
  end

  // Next-state and handshake decode of the issue FSM.
  always_comb begin
    w_next_state = r_state;
    w_warp_take  = 1'b0;
    w_inst_avail = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (warp_rdy) begin
          w_warp_take = 1'b1;
          // A zero-length warp has nothing to issue; go straight to waiting.
          if (w_n_clamped == {INST_BW{1'b0}}) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_ISSUE;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_inst_avail = (r_out < OUT_BW'(MAX_OUT));
        if (w_inst_avail && inst_ack && (w_pc_inc == r_n_inst)) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (r_out == {OUT_BW{1'b0}}) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is applied, so nothing is
  // offered or accepted during the reset cycle whatever state it interrupts.
  assign warp_ack       = w_warp_take & ~i_rst;
  assign inst_rdy       = w_inst_avail & ~i_rst;
  assign warp_done_dval = w_done & ~i_rst;
  assign w_inst_fire    = inst_rdy & inst_ack;

  // Outside ISSUE the pc output keeps the last pc that was presented.
  assign o_pc       = i_rst ? {INST_BW{1'b0}} :
                      ((r_state == ST_ISSUE) ? r_pc : r_hold_pc);
  assign o_wid      = i_rst ? {WID_BW{1'b0}} : r_wid;
  assign o_done_wid = i_rst ? {WID_BW{1'b0}} : r_wid;
  assign o_bofs     = i_rst ? {OFS_BW{1'b0}} : r_bofs;
  assign o_aofs     = i_rst ? {OFS_BW{1'b0}} : r_aofs;
  assign o_err      = r_err;

  // Outstanding-count update: an issue and a commit in the same cycle cancel;
  // a lone commit with nothing outstanding is an underflow and saturates at 0.
  always_comb begin
    w_out_next  = r_out;
    w_underflow = 1'b0;
    if (w_inst_fire && inst_commit_dval) begin
      w_out_next = r_out;
    end else if (w_inst_fire) begin
      w_out_next = r_out + {{(OUT_BW-1){1'b0}}, 1'b1};
    end else if (inst_commit_dval) begin
      if (r_out == {OUT_BW{1'b0}}) begin
        w_underflow = 1'b1;
      end else begin
        w_out_next = r_out - {{(OUT_BW-1){1'b0}}, 1'b1};
      end
    end else begin
      w_out_next = r_out;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Warp payload latch, taken on the accepting cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wid    <= {WID_BW{1'b0}};
      r_bofs   <= {OFS_BW{1'b0}};
      r_aofs   <= {OFS_BW{1'b0}};
      r_n_inst <= {INST_BW{1'b0}};
    end else if (warp_ack) begin
      r_wid    <= i_wid;
      r_bofs   <= i_bofs;
      r_aofs   <= i_aofs;
      r_n_inst <= w_n_clamped;
    end
  end

  // Program counter: cleared per warp, advanced by each accepted issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= {INST_BW{1'b0}};
    end else if (warp_ack) begin
      r_pc <= {INST_BW{1'b0}};
    end else if (w_inst_fire) begin
      r_pc <= w_pc_inc;
    end
  end

  // Remember the pc shown during ISSUE so it can be held afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_pc <= {INST_BW{1'b0}};
    end else if (r_state == ST_ISSUE) begin
      r_hold_pc <= r_pc;
    end
  end

  // Outstanding counter and sticky underflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= {OUT_BW{1'b0}};
      r_err <= 1'b0;
    end else begin
      r_out <= w_out_next;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_warp_inst_issuer.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for warp_inst_issuer. The stimulus side pushes the expected
// instruction stream and done id into queues when a warp is accepted; a
// monitor sampling mid-cycle pops and compares whenever the DUT issues or
// signals done, and tracks outstanding/error state from commit arithmetic.
// -----------------------------------------------------------------------------
module tb_warp_inst_issuer;

  localparam int MAX_OUT = 4;
  localparam int N_INST  = 8;

  logic        clk;
  logic        i_rst;
  logic        warp_rdy;
  logic        warp_ack;
  logic [1:0]  i_wid;
  logic [95:0] i_bofs;
  logic [95:0] i_aofs;
  logic [3:0]  i_n_inst;
  logic        inst_rdy;
  logic        inst_ack;
  logic [3:0]  o_pc;
  logic [1:0]  o_wid;
  logic [95:0] o_bofs;
  logic [95:0] o_aofs;
  logic        inst_commit_dval;
  logic        warp_done_dval;
  logic [1:0]  o_done_wid;
  logic        o_err;

  warp_inst_issuer dut (
    .i_clk(clk), .i_rst(i_rst),
    .warp_rdy(warp_rdy), .warp_ack(warp_ack),
    .i_wid(i_wid), .i_bofs(i_bofs), .i_aofs(i_aofs), .i_n_inst(i_n_inst),
    .inst_rdy(inst_rdy), .inst_ack(inst_ack),
    .o_pc(o_pc), .o_wid(o_wid), .o_bofs(o_bofs), .o_aofs(o_aofs),
    .inst_commit_dval(inst_commit_dval),
    .warp_done_dval(warp_done_dval), .o_done_wid(o_done_wid), .o_err(o_err)
  );

  typedef struct {
    logic [3:0]  pc;
    logic [1:0]  wid;
    logic [95:0] bofs;
    logic [95:0] aofs;
  } exp_t;

  exp_t       exp_inst[$];
  logic [1:0] exp_done[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state (state after the most recent clock edge)
  int          m_out = 0;
  bit          m_err = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done_now = 1'b0;
  logic [3:0]  m_hold = 4'd0;
  logic [1:0]  m_wid = 2'd0;
  logic [95:0] m_bofs = 96'd0;
  logic [95:0] m_aofs = 96'd0;

  // stimulus knobs
  int ack_pct = 0;
  int commit_pct = 0;
  bit force_commit = 1'b0;
  bit rst_req = 1'b1;
  bit rst_pulse = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // per-cycle driver for reset, instruction ack and commit pulses
  initial begin
    i_rst = 1'b1;
    inst_ack = 1'b0;
    inst_commit_dval = 1'b0;
  end
  always begin
    @(posedge clk);
    #1;
    i_rst = rst_req || rst_pulse;
    rst_pulse = 1'b0;
    inst_ack = ($urandom_range(99) < ack_pct);
    inst_commit_dval = force_commit || ((m_out > 0) && ($urandom_range(99) < commit_pct));
    force_commit = 1'b0;
  end

  // monitor / scoreboard
  always begin : mon_p
    bit drain_now;
    bit issuing;
    bit fire;
    exp_t e;
    @(negedge clk);
    #1;
    if (i_rst) begin
      chk("rst_warp_ack", warp_ack, 0);
      chk("rst_inst_rdy", inst_rdy, 0);
      chk("rst_done", warp_done_dval, 0);
      chk("rst_o_pc", o_pc, 0);
      chk("rst_o_wid", o_wid, 0);
      chk("rst_o_done_wid", o_done_wid, 0);
      chk("rst_o_bofs", o_bofs, 0);
      chk("rst_o_aofs", o_aofs, 0);
      exp_inst.delete();
      exp_done.delete();
      m_out = 0; m_err = 1'b0; m_active = 1'b0; m_done_now = 1'b0;
      m_hold = 4'd0; m_wid = 2'd0; m_bofs = 96'd0; m_aofs = 96'd0;
    end else begin
      drain_now = m_active && !m_done_now && (exp_inst.size() == 0) && (m_out == 0);
      issuing   = m_active && !m_done_now && (exp_inst.size() > 0);
      chk("warp_ack", warp_ack, warp_rdy && !m_active);
      chk("inst_rdy", inst_rdy, issuing && (m_out < MAX_OUT));
      chk("warp_done_dval", warp_done_dval, m_done_now);
      chk("o_err", o_err, m_err);
      chk("o_wid", o_wid, m_wid);
      chk("o_bofs", o_bofs, m_bofs);
      chk("o_aofs", o_aofs, m_aofs);
      if (issuing) begin
        chk("o_pc_issue", o_pc, exp_inst[0].pc);
        m_hold = exp_inst[0].pc;
      end else begin
        chk("o_pc_hold", o_pc, m_hold);
      end
      if (m_done_now) begin
        if (exp_done.size() > 0) begin
          chk("o_done_wid", o_done_wid, exp_done.pop_front());
        end else begin
          chk("done_queue_empty", 1, 0);
        end
      end
      fire = inst_rdy && inst_ack;
      if (fire && exp_inst.size() > 0) begin
        e = exp_inst.pop_front();
        chk("issue_pc", o_pc, e.pc);
        chk("issue_wid", o_wid, e.wid);
        chk("issue_bofs", o_bofs, e.bofs);
        chk("issue_aofs", o_aofs, e.aofs);
      end
      if (fire && !inst_commit_dval) begin
        m_out++;
      end else if (!fire && inst_commit_dval) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end
      if (m_done_now) begin
        m_done_now = 1'b0;
        m_active = 1'b0;
      end else if (drain_now) begin
        m_done_now = 1'b1;
      end
      if (warp_rdy && warp_ack) begin
        m_active = 1'b1;
        m_wid = i_wid;
        m_bofs = i_bofs;
        m_aofs = i_aofs;
      end
    end
  end

  task automatic send_warp(input int wid, input int n);
    bit got;
    int nc;
    exp_t e;
    @(posedge clk);
    #2;
    i_wid = 2'(wid);
    i_n_inst = 4'(n);
    i_bofs = {$urandom, $urandom, $urandom};
    i_aofs = {$urandom, $urandom, $urandom};
    warp_rdy = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (warp_ack) begin
        got = 1'b1;
        nc = (n > N_INST) ? N_INST : n;
        for (int p = 0; p < nc; p++) begin
          e.pc = 4'(p); e.wid = i_wid; e.bofs = i_bofs; e.aofs = i_aofs;
          exp_inst.push_back(e);
        end
        exp_done.push_back(i_wid);
      end
    end
    if (!got) chk("warp_accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    warp_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      #2;
      if (!m_active && exp_inst.size() == 0 && exp_done.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin : main_p
    bit seen;
    warp_rdy = 1'b0;
    i_wid = 2'd0;
    i_n_inst = 4'd0;
    i_bofs = 96'd0;
    i_aofs = 96'd0;
    repeat (3) @(posedge clk);
    rst_req = 1'b0;
    repeat (2) @(posedge clk);

    // basic warp and zero-length warp
    ack_pct = 100; commit_pct = 60;
    send_warp(2, 3);
    wait_idle();
    send_warp(1, 0);
    wait_idle();

    // randomized warps, including counts above N_INST
    for (int w = 0; w < 25; w++) begin
      ack_pct = $urandom_range(100, 30);
      commit_pct = $urandom_range(90, 20);
      repeat ($urandom_range(3)) @(posedge clk);
      send_warp($urandom_range(3), $urandom_range(11));
    end
    send_warp(0, 15);
    wait_idle();

    // backpressure: fill to MAX_OUT, hold, then release with commits
    ack_pct = 100; commit_pct = 0;
    send_warp(3, 8);
    repeat (12) @(posedge clk);
    commit_pct = 50;
    wait_idle();

    // underflow while idle
    commit_pct = 0;
    @(posedge clk);
    force_commit = 1'b1;
    repeat (4) @(posedge clk);

    // mid-operation reset while pc=2 is presented
    ack_pct = 100;
    send_warp(1, 8);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      #2;
      if (inst_rdy && inst_ack && o_pc == 4'd1) seen = 1'b1;
    end
    if (!seen) chk("pc1_timeout", 0, 1);
    @(posedge clk);
    rst_pulse = 1'b1;
    ack_pct = 0;
    send_warp(0, 2);
    // late commit for an instruction issued before the reset
    force_commit = 1'b1;
    repeat (2) @(posedge clk);
    ack_pct = 100; commit_pct = 50;
    wait_idle();

    // final reset clears the sticky error
    @(posedge clk);
    rst_pulse = 1'b1;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
